// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered common data bus among NUM_FU functional units.
// Define CDB_ARB_PERF_EN to add saturating grant/conflict/hold performance counters.
module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int ID_W   = 4,
    parameter int VAL_W  = 8,
    localparam int PTR_W = $clog2(NUM_FU)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_FU-1:0]       fu_req,
    input  logic [NUM_FU*ID_W-1:0]  fu_id,
    input  logic [NUM_FU*VAL_W-1:0] fu_val,
    input  logic                    cdb_hold,
    input  logic                    flush,
    output logic [NUM_FU-1:0]       fu_grant,
    output logic                    cdb_valid,
    output logic [ID_W-1:0]         cdb_id,
    output logic [VAL_W-1:0]        cdb_val,
    output logic [PTR_W-1:0]        rr_ptr
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [15:0]             perf_grants,
    output logic [15:0]             perf_conflict,
    output logic [15:0]             perf_hold
`endif
);

    // Handshake: fu_req[i] is a valid that stays high with fu_id/fu_val stable until
    // fu_grant[i] (the ready) is seen high; the transfer happens on that clock edge.
    logic [NUM_FU-1:0] grant;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  next_ptr;
    logic              granted;
    logic [PTR_W:0]    sum;
    logic [PTR_W-1:0]  cand;
    logic [ID_W-1:0]   sel_id;
    logic [VAL_W-1:0]  sel_val;

    // Scan requesters starting at rr_ptr; the first one found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        granted   = 1'b0;
        sum       = '0;
        cand      = '0;
        if (rst && !flush && !cdb_hold) begin
            for (int k = 0; k < NUM_FU; k++) begin
                sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (sum >= (PTR_W+1)'(NUM_FU)) begin
                    sum = sum - (PTR_W+1)'(NUM_FU);
                end
                cand = sum[PTR_W-1:0];
                if (!granted && fu_req[cand]) begin
                    granted         = 1'b1;
                    grant[cand]     = 1'b1;
                    grant_idx       = cand;
                end
            end
        end
    end

    always_comb begin
        next_ptr = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
        sel_id   = fu_id[grant_idx*ID_W +: ID_W];
        sel_val  = fu_val[grant_idx*VAL_W +: VAL_W];
    end

    assign fu_grant = grant;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cdb_valid <= 1'b0;
            cdb_id    <= '0;
            cdb_val   <= '0;
            rr_ptr    <= '0;
        end else begin
            cdb_valid <= granted;
            if (granted) begin
                cdb_id  <= sel_id;
                cdb_val <= sel_val;
                rr_ptr  <= next_ptr;
            end
        end
    end

`ifdef CDB_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_grants   <= '0;
            perf_conflict <= '0;
            perf_hold     <= '0;
        end else begin
            if (granted && perf_grants != 16'hFFFF) begin
                perf_grants <= perf_grants + 16'd1;
            end
            if (granted && ($countones(fu_req) > 1) && perf_conflict != 16'hFFFF) begin
                perf_conflict <= perf_conflict + 16'd1;
            end
            // Counted even when flush is also active.
            if (cdb_hold && (|fu_req) && perf_hold != 16'hFFFF) begin
                perf_hold <= perf_hold + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model checked every cycle plus hand-computed vectors.
// Exercises the perf counters as well when CDB_ARB_PERF_EN is defined.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int IW = 4;
    localparam int VW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    fu_req;
    logic [N*IW-1:0] fu_id;
    logic [N*VW-1:0] fu_val;
    logic            cdb_hold;
    logic            flush;
    logic [N-1:0]    fu_grant;
    logic            cdb_valid;
    logic [IW-1:0]   cdb_id;
    logic [VW-1:0]   cdb_val;
    logic [1:0]      rr_ptr;
`ifdef CDB_ARB_PERF_EN
    logic [15:0]     perf_grants;
    logic [15:0]     perf_conflict;
    logic [15:0]     perf_hold;
`endif

    cdb_arbiter #(.NUM_FU(N), .ID_W(IW), .VAL_W(VW)) dut (
        .clk(clk), .rst(rst), .fu_req(fu_req), .fu_id(fu_id), .fu_val(fu_val),
        .cdb_hold(cdb_hold), .flush(flush), .fu_grant(fu_grant),
        .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val), .rr_ptr(rr_ptr)
`ifdef CDB_ARB_PERF_EN
        , .perf_grants(perf_grants), .perf_conflict(perf_conflict), .perf_hold(perf_hold)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pointer as an integer, broadcasts as a queue of {id,val}.
    int                 m_ptr   = 0;
    logic               m_valid = 1'b0;
    logic [IW-1:0]      m_id    = '0;
    logic [VW-1:0]      m_val   = '0;
    logic [IW+VW-1:0]   exp_q[$];
    int                 m_grants = 0, m_conflict = 0, m_hold = 0;

    function automatic logic [N-1:0] model_grant(input logic r, input logic h, input logic f,
                                                 input logic [N-1:0] req, input int ptr);
        if (!r || h || f) return '0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (req[i]) return N'(1) << i;
        end
        return '0;
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] g;
        g = model_grant(rst, cdb_hold, flush, fu_req, m_ptr);
        if (!rst) begin
            m_ptr = 0; m_valid = 1'b0; m_id = '0; m_val = '0;
            m_grants = 0; m_conflict = 0; m_hold = 0;
            exp_q.delete();
        end else begin
            if (cdb_hold && (fu_req != 0)) m_hold = sat(m_hold);
            if (g != 0) begin
                for (int i = 0; i < N; i++) begin
                    if (g[i]) begin
                        m_id  = fu_id[i*IW +: IW];
                        m_val = fu_val[i*VW +: VW];
                        m_ptr = (i + 1) % N;
                    end
                end
                m_valid = 1'b1;
                exp_q.push_back({m_id, m_val});
                m_grants = sat(m_grants);
                if ($countones(fu_req) >= 2) m_conflict = sat(m_conflict);
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [IW+VW-1:0] e;
        check("grant", 32'(fu_grant), 32'(model_grant(rst, cdb_hold, flush, fu_req, m_ptr)));
        check("cdb_valid", 32'(cdb_valid), 32'(m_valid));
        check("rr_ptr", 32'(rr_ptr), 32'(m_ptr));
        check("cdb_id", 32'(cdb_id), 32'(m_id));
        check("cdb_val", 32'(cdb_val), 32'(m_val));
        if (m_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("broadcast", 32'({cdb_id, cdb_val}), 32'(e));
        end
`ifdef CDB_ARB_PERF_EN
        check("perf_grants", 32'(perf_grants), 32'(m_grants));
        check("perf_conflict", 32'(perf_conflict), 32'(m_conflict));
        check("perf_hold", 32'(perf_hold), 32'(m_hold));
`endif
    end

    // ---------------- driver tasks ----------------
    logic auto_drop = 1'b0;

    // Advance one clock; granted FUs drop their request just after the edge.
    task automatic step();
        logic [N-1:0] g;
        @(negedge clk);
        g = fu_grant;
        @(posedge clk);
        #1;
        if (auto_drop) fu_req = fu_req & ~g;
    endtask

    task automatic do_reset();
        rst = 1'b0; fu_req = '0; cdb_hold = 1'b0; flush = 1'b0; auto_drop = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
    endtask

    typedef struct { logic [N-1:0] req; logic hold; logic flush; } vec_t;
    vec_t tbl[10];

    // ---------------- directed stimulus ----------------
    initial begin
        logic [N-1:0] rr_seq[4];
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        tbl = '{'{4'b1010, 1'b0, 1'b0}, '{4'b0110, 1'b0, 1'b1}, '{4'b1111, 1'b1, 1'b0},
                '{4'b0101, 1'b0, 1'b0}, '{4'b1001, 1'b1, 1'b1}, '{4'b0011, 1'b0, 1'b0},
                '{4'b1100, 1'b0, 1'b0}, '{4'b1110, 1'b0, 1'b1}, '{4'b0111, 1'b0, 1'b0},
                '{4'b1000, 1'b0, 1'b0}};

        fu_id  = {4'hD, 4'h9, 4'h7, 4'h5};
        fu_val = {8'h3C, 8'hA5, 8'h66, 8'h11};

        // Reset with all requesting
        rst = 1'b0; fu_req = 4'b1111; cdb_hold = 1'b0; flush = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            step();
            check("t1_grant_in_reset", 32'(fu_grant), 32'h0);
            check("t1_valid_in_reset", 32'(cdb_valid), 32'h0);
            check("t1_ptr_in_reset", 32'(rr_ptr), 32'h0);
        end
        rst = 1'b1;
        #1;
        check("t1_first_grant", 32'(fu_grant), 32'b0001);
        auto_drop = 1'b1;
        step();
        check("t1_first_id", 32'(cdb_id), 32'h5);
        check("t1_ptr_after", 32'(rr_ptr), 32'h1);

        // Single requester
        do_reset();
        fu_req = 4'b0100; auto_drop = 1'b1;
        #1;
        check("t2_grant", 32'(fu_grant), 32'b0100);
        step();
        check("t2_valid", 32'(cdb_valid), 32'h1);
        check("t2_id", 32'(cdb_id), 32'h9);
        check("t2_val", 32'(cdb_val), 32'hA5);
        check("t2_ptr", 32'(rr_ptr), 32'h3);

        // Round robin over all four
        do_reset();
        fu_req = 4'b1111; auto_drop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_grant", 32'(fu_grant), 32'(rr_seq[k]));
            step();
            check("t3_valid", 32'(cdb_valid), 32'h1);
        end
        check("t3_ptr_wrap", 32'(rr_ptr), 32'h0);
        check("t3_last_val", 32'(cdb_val), 32'h3C);

        // Hold with rr_ptr=1
        do_reset();
        fu_req = 4'b0001; auto_drop = 1'b1;
        step();
        fu_req = 4'b0011; cdb_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t4_grant_held", 32'(fu_grant), 32'h0);
            step();
            check("t4_valid_held", 32'(cdb_valid), 32'h0);
            check("t4_id_held", 32'(cdb_id), 32'h5);
            check("t4_val_held", 32'(cdb_val), 32'h11);
            check("t4_ptr_held", 32'(rr_ptr), 32'h1);
        end
        cdb_hold = 1'b0;
        #1;
        check("t4_grant_release", 32'(fu_grant), 32'b0010);
        step();
        check("t4_id_release", 32'(cdb_id), 32'h7);

        // Flush together with hold
        do_reset();
        fu_req = 4'b1000; flush = 1'b1; cdb_hold = 1'b1;
        #1;
        check("t5_grant", 32'(fu_grant), 32'h0);
        step();
        check("t5_valid", 32'(cdb_valid), 32'h0);
        check("t5_ptr", 32'(rr_ptr), 32'h0);
        flush = 1'b0; cdb_hold = 1'b0;
        #1;
        check("t5_grant_after", 32'(fu_grant), 32'b1000);
        rst = 1'b0;
        #1;
        check("reset_kills_grant", 32'(fu_grant), 32'h0);
        step();
        check("reset_discards_bcast", 32'(cdb_valid), 32'h0);
        rst = 1'b1;

        // Mixed directed patterns, model-checked every cycle
        auto_drop = 1'b1;
        for (int v = 0; v < 10; v++) begin
            fu_req = fu_req | tbl[v].req;
            cdb_hold = tbl[v].hold;
            flush = tbl[v].flush;
            fu_id[3*IW +: IW] = IW'($urandom_range(0, 15));
            step();
        end
        cdb_hold = 1'b0; flush = 1'b0;
        for (int c = 0; c < 6; c++) step();
        check("table_drained", 32'(fu_req), 32'h0);

`ifdef CDB_ARB_PERF_EN
        do_reset();
        fu_req = 4'b0011; auto_drop = 1'b1;
        step();
        step();
        fu_req = 4'b0001; cdb_hold = 1'b1;
        step();
        check("t6_grants", 32'(perf_grants), 32'd2);
        check("t6_conflict", 32'(perf_conflict), 32'd1);
        check("t6_hold", 32'(perf_hold), 32'd1);
        for (int c = 0; c < 65536; c++) step();
        check("t6_hold_sat", 32'(perf_hold), 32'hFFFF);
        check("t6_grants_kept", 32'(perf_grants), 32'd2);
        cdb_hold = 1'b0;
`endif

        step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
